// File: rtl/tri_job_sched.sv
// tri_job_sched: round-robin scheduler sharing one triangle rasterizer engine.
// A granted requester's three vertices are streamed to the engine over three
// load cycles. The emitted pixels are then counted until busy falls or a
// watchdog expires. Completion is reported with id, count and error flag.
module tri_job_sched #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned IDW       = 2,
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned BUSY_WAIT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [18*NUM_REQ-1:0]   req_vtx,
    output logic [NUM_REQ-1:0]      req_ack,
    output logic                    eng_nt,
    output logic [2:0]              eng_xi,
    output logic [2:0]              eng_yi,
    input  logic                    eng_busy,
    input  logic                    eng_po,
    output logic                    sched_busy,
    output logic                    done,
    output logic [IDW-1:0]          done_id,
    output logic [6:0]              done_cnt,
    output logic                    done_err
);

    localparam int unsigned VTXW    = 18;
    localparam int unsigned CNTW    = 7;
    localparam int unsigned PIX_MAX = 64;
    localparam int unsigned WD_MAX  = (TIMEOUT > BUSY_WAIT) ? TIMEOUT : BUSY_WAIT;
    localparam int unsigned WDW     = $clog2(WD_MAX + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD1     = 3'd1;
    localparam logic [2:0] S_LOAD2     = 3'd2;
    localparam logic [2:0] S_LOAD3     = 3'd3;
    localparam logic [2:0] S_WAIT_BUSY = 3'd4;
    localparam logic [2:0] S_RUN       = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    logic [2:0]         state_q, state_d;
    logic [IDW-1:0]     rr_q, rr_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [VTXW-1:0]    vtx_q, vtx_d;
    logic [CNTW-1:0]    pix_q, pix_d;
    logic [WDW-1:0]     wd_q, wd_d;

    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               nt_q, nt_d;
    logic [2:0]         xi_q, xi_d;
    logic [2:0]         yi_q, yi_d;
    logic               sbusy_q, sbusy_d;
    logic               done_q, done_d;
    logic [IDW-1:0]     done_id_q, done_id_d;
    logic [CNTW-1:0]    done_cnt_q, done_cnt_d;
    logic               done_err_q, done_err_d;

    logic               gnt_vld;
    logic [IDW-1:0]     gnt_id;
    logic [VTXW-1:0]    gnt_vtx;
    int unsigned        cand;
    logic [CNTW-1:0]    pix_po;

    // Round-robin pick: first set request searching upward from rr+1, wrapping.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        gnt_vtx = '0;
        cand    = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = (32'(rr_q) + i) % NUM_REQ;
            if (!gnt_vld && req[cand]) begin
                gnt_vld = 1'b1;
                gnt_id  = IDW'(cand);
                gnt_vtx = req_vtx[cand*VTXW +: VTXW];
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        id_d       = id_q;
        vtx_d      = vtx_q;
        pix_d      = pix_q;
        wd_d       = wd_q;
        ack_d      = '0;
        nt_d       = 1'b0;
        xi_d       = xi_q;
        yi_d       = yi_q;
        done_d     = 1'b0;
        done_id_d  = done_id_q;
        done_cnt_d = done_cnt_q;
        done_err_d = done_err_q;

        // Pixel count including this cycle's po, saturating at 64.
        pix_po = (eng_po && (pix_q != CNTW'(PIX_MAX))) ? pix_q + CNTW'(1) : pix_q;

        case (state_q)
            S_IDLE: begin
                if (gnt_vld) begin
                    rr_d    = gnt_id;
                    id_d    = gnt_id;
                    vtx_d   = gnt_vtx;
                    ack_d   = NUM_REQ'(1) << gnt_id;
                    nt_d    = 1'b1;
                    xi_d    = gnt_vtx[17:15];
                    yi_d    = gnt_vtx[14:12];
                    pix_d   = '0;
                    wd_d    = '0;
                    state_d = S_LOAD1;
                end
            end
            S_LOAD1: begin
                xi_d    = vtx_q[11:9];
                yi_d    = vtx_q[8:6];
                state_d = S_LOAD2;
            end
            S_LOAD2: begin
                xi_d    = vtx_q[5:3];
                yi_d    = vtx_q[2:0];
                state_d = S_LOAD3;
            end
            S_LOAD3: begin
                wd_d    = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (eng_busy) begin
                    wd_d    = '0;
                    pix_d   = pix_po;
                    state_d = S_RUN;
                end else if (wd_q == WDW'(BUSY_WAIT - 1)) begin
                    done_d     = 1'b1;
                    done_id_d  = id_q;
                    done_cnt_d = '0;
                    done_err_d = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            S_RUN: begin
                pix_d = pix_po;
                if (!eng_busy) begin
                    done_d     = 1'b1;
                    done_id_d  = id_q;
                    done_cnt_d = pix_po;
                    done_err_d = 1'b0;
                    state_d    = S_DONE;
                end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                    done_d     = 1'b1;
                    done_id_d  = id_q;
                    done_cnt_d = pix_po;
                    done_err_d = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            S_DONE: begin
                pix_d   = '0;
                wd_d    = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        sbusy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rr_q       <= IDW'(NUM_REQ - 1);
            id_q       <= '0;
            vtx_q      <= '0;
            pix_q      <= '0;
            wd_q       <= '0;
            ack_q      <= '0;
            nt_q       <= 1'b0;
            xi_q       <= '0;
            yi_q       <= '0;
            sbusy_q    <= 1'b0;
            done_q     <= 1'b0;
            done_id_q  <= '0;
            done_cnt_q <= '0;
            done_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            id_q       <= id_d;
            vtx_q      <= vtx_d;
            pix_q      <= pix_d;
            wd_q       <= wd_d;
            ack_q      <= ack_d;
            nt_q       <= nt_d;
            xi_q       <= xi_d;
            yi_q       <= yi_d;
            sbusy_q    <= sbusy_d;
            done_q     <= done_d;
            done_id_q  <= done_id_d;
            done_cnt_q <= done_cnt_d;
            done_err_q <= done_err_d;
        end
    end

    assign req_ack    = ack_q;
    assign eng_nt     = nt_q;
    assign eng_xi     = xi_q;
    assign eng_yi     = yi_q;
    assign sched_busy = sbusy_q;
    assign done       = done_q;
    assign done_id    = done_id_q;
    assign done_cnt   = done_cnt_q;
    assign done_err   = done_err_q;

endmodule

// File: tb/tb_tri_job_sched.sv
// Testbench for tri_job_sched: behavioural engine, request model and scoreboard.
`timescale 1ns/1ps
module tb_tri_job_sched;

    localparam int NUM_REQ   = 4;
    localparam int IDW       = 2;
    localparam int TIMEOUT   = 255;
    localparam int BUSY_WAIT = 4;
    localparam int PIX_MAX   = 64;

    typedef struct {
        int     id;
        int     cnt;
        int     err;
        int     lat;
        longint nt_cyc;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NUM_REQ-1:0]    req;
    logic [18*NUM_REQ-1:0] req_vtx;
    logic [NUM_REQ-1:0]    req_ack;
    logic                  eng_nt;
    logic [2:0]            eng_xi;
    logic [2:0]            eng_yi;
    logic                  eng_busy;
    logic                  eng_po;
    logic                  sched_busy;
    logic                  done;
    logic [IDW-1:0]        done_id;
    logic [6:0]            done_cnt;
    logic                  done_err;

    int          checks = 0;
    int          errors = 0;
    longint      cyc = 0;
    logic [NUM_REQ-1:0] req_prev = '0;

    // Request model: requester i asks while it has more wants than grants.
    int          want_cnt [NUM_REQ];
    int          got_cnt  [NUM_REQ];
    logic [17:0] vtx      [NUM_REQ];
    int          cfg_raise[NUM_REQ];
    int          cfg_len  [NUM_REQ];
    int          cfg_npo  [NUM_REQ];
    int          cfg_fall [NUM_REQ];

    exp_t   sb_q[$];
    int     grant_log[$];
    longint nt_log[$];
    longint done_log[$];
    bit     eng_active = 1'b0;
    bit     eng_kill = 1'b0;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        assign req[g] = (want_cnt[g] != got_cnt[g]);
        assign req_vtx[g*18 +: 18] = vtx[g];
    end

    tri_job_sched #(
        .NUM_REQ(NUM_REQ), .IDW(IDW), .TIMEOUT(TIMEOUT), .BUSY_WAIT(BUSY_WAIT)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_vtx(req_vtx), .req_ack(req_ack),
        .eng_nt(eng_nt), .eng_xi(eng_xi), .eng_yi(eng_yi), .eng_busy(eng_busy),
        .eng_po(eng_po), .sched_busy(sched_busy), .done(done), .done_id(done_id),
        .done_cnt(done_cnt), .done_err(done_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        req_prev <= req;
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Expected job outcome from the engine's configured behaviour.
    // Busy rises three cycles after the load strobe; latency is strobe to done.
    function automatic exp_t model(input int id, input longint ntc);
        exp_t e;
        e.id     = id;
        e.nt_cyc = ntc;
        if (cfg_raise[id] == 0) begin
            e.err = 1;
            e.cnt = 0;
            e.lat = 3 + BUSY_WAIT;
        end else if (cfg_len[id] > TIMEOUT) begin
            e.err = 1;
            e.cnt = min2(min2(cfg_npo[id], TIMEOUT + 1), PIX_MAX);
            e.lat = TIMEOUT + 4;
        end else begin
            e.err = 0;
            e.cnt = min2(cfg_npo[id] + cfg_fall[id], PIX_MAX);
            e.lat = cfg_len[id] + 4;
        end
        return e;
    endfunction

    // Behavioural engine plus grant/load checker, triggered by the load strobe.
    initial begin : engine
        int rr_m;
        int pick;
        int c;
        logic [17:0] v;
        eng_busy = 1'b0;
        eng_po   = 1'b0;
        rr_m     = NUM_REQ - 1;
        forever begin
            @(negedge clk);
            if (reset) begin
                rr_m = NUM_REQ - 1;
            end else if (eng_nt === 1'b1) begin
                eng_active = 1'b1;
                pick = -1;
                for (int i = 1; i <= NUM_REQ; i++) begin
                    c = (rr_m + i) % NUM_REQ;
                    if (pick < 0 && req_prev[c]) pick = c;
                end
                if (pick < 0) begin
                    checks++;
                    errors++;
                    $display("FAIL grant_no_request: ack %b with no request pending", req_ack);
                    eng_active = 1'b0;
                end else begin
                    check("req_ack", longint'(req_ack), longint'(1 << pick));
                    rr_m = pick;
                    got_cnt[pick]++;
                    grant_log.push_back(pick);
                    nt_log.push_back(cyc);
                    sb_q.push_back(model(pick, cyc));
                    v = vtx[pick];
                    check("v1_x", eng_xi, v[17:15]);
                    check("v1_y", eng_yi, v[14:12]);
                    @(negedge clk);
                    check("ld2_nt", eng_nt, 0);
                    check("ld2_ack", req_ack, 0);
                    check("v2_x", eng_xi, v[11:9]);
                    check("v2_y", eng_yi, v[8:6]);
                    @(negedge clk);
                    check("ld3_nt", eng_nt, 0);
                    check("v3_x", eng_xi, v[5:3]);
                    check("v3_y", eng_yi, v[2:0]);
                    if (cfg_raise[pick] != 0) begin
                        for (int j = 0; j < cfg_len[pick]; j++) begin
                            @(negedge clk);
                            if (eng_kill) break;
                            eng_busy = 1'b1;
                            eng_po   = (j < cfg_npo[pick]);
                        end
                        if (!eng_kill) begin
                            @(negedge clk);
                            eng_busy = 1'b0;
                            eng_po   = (cfg_fall[pick] != 0);
                            @(negedge clk);
                        end
                        eng_busy = 1'b0;
                        eng_po   = 1'b0;
                    end
                    eng_active = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor: pops one expected record per done pulse.
    initial begin : done_mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_log.push_back(cyc);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected: done id %0d cnt %0d with nothing expected", done_id, done_cnt);
                end else begin
                    e = sb_q.pop_front();
                    check("done_id", done_id, e.id);
                    check("done_cnt", done_cnt, e.cnt);
                    check("done_err", done_err, e.err);
                    check("done_latency", cyc - e.nt_cyc, e.lat);
                end
            end
        end
    end

    // Per-cycle protocol checks: sched_busy window, strobe rules.
    initial begin : cyc_mon
        bit exp_sb;
        bit rst_prev;
        exp_sb   = 1'b0;
        rst_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_prev) exp_sb = 1'b0;
            if (eng_nt === 1'b1) exp_sb = 1'b1;
            if (!reset) check("sched_busy", sched_busy, exp_sb);
            if (eng_nt === 1'b1 && eng_busy) begin
                checks++;
                errors++;
                $display("FAIL nt_while_busy: eng_nt %b eng_busy %b", eng_nt, eng_busy);
            end
            if (req_ack !== '0 && eng_nt !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL ack_without_nt: req_ack %b eng_nt %b", req_ack, eng_nt);
            end
            if (done === 1'b1) exp_sb = 1'b0;
            rst_prev = reset;
        end
    end

    task automatic request(input int id, input logic [17:0] v, input int raise,
                           input int len, input int npo, input int fall);
        vtx[id]       = v;
        cfg_raise[id] = raise;
        cfg_len[id]   = len;
        cfg_npo[id]   = npo;
        cfg_fall[id]  = fall;
        want_cnt[id]++;
    endtask

    function automatic bit all_served();
        for (int i = 0; i < NUM_REQ; i++)
            if (want_cnt[i] != got_cnt[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (all_served() && sb_q.size() == 0 && !eng_active && sched_busy === 1'b0) break;
            n++;
            if (n >= max_cyc) begin
                checks++;
                errors++;
                $display("FAIL wait_idle: no idle within %0d cycles (queue %0d)", max_cyc, sb_q.size());
                break;
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {req_ack, eng_nt, eng_xi, eng_yi, sched_busy}, 0);
        check({tag, "_done"}, {done, done_id, done_cnt, done_err}, 0);
    endtask

    initial begin : main
        int exp_order[5];
        int len;
        int mask;
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < NUM_REQ; i++) begin
            want_cnt[i] = 0; got_cnt[i] = 0; vtx[i] = '0;
            cfg_raise[i] = 1; cfg_len[i] = 1; cfg_npo[i] = 0; cfg_fall[i] = 0;
        end

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_zero("reset");

        // All four requesting, requester 0 twice: order 0,1,2,3,0 back to back.
        grant_log.delete(); nt_log.delete(); done_log.delete();
        for (int i = 0; i < NUM_REQ; i++)
            request(i, 18'($urandom), 1, 3 + i, i, 0);
        want_cnt[0]++;
        wait_idle(500);
        check("rr_jobs", grant_log.size(), 5);
        if (grant_log.size() == 5 && done_log.size() >= 4) begin
            for (int k = 0; k < 5; k++) check("rr_order", grant_log[k], exp_order[k]);
            for (int k = 1; k < 5; k++) check("b2b_gap", nt_log[k] - done_log[k-1], 2);
        end

        // Single job on requester 2, right triangle, 15 pixels.
        grant_log.delete();
        request(2, {3'd0, 3'd0, 3'd4, 3'd0, 3'd0, 3'd4}, 1, 15, 15, 0);
        wait_idle(200);
        check("single_grant", grant_log.size() > 0 ? grant_log[0] : -1, 2);

        // Engine never raises busy.
        request(1, 18'($urandom), 0, 0, 0, 0);
        wait_idle(200);

        // Engine hangs busy for 300 cycles with 10 pixels.
        request(3, 18'($urandom), 1, 300, 10, 0);
        wait_idle(800);

        // Pixel on the busy-fall cycle counts.
        request(0, 18'($urandom), 1, 5, 2, 1);
        wait_idle(200);

        // 70 pixels saturate at 64.
        request(2, 18'($urandom), 1, 69, 69, 1);
        wait_idle(300);

        // Random job mixes from random requester subsets.
        repeat (15) begin
            mask = $urandom_range(1, (1 << NUM_REQ) - 1);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (mask[i]) begin
                    len = $urandom_range(1, 60);
                    request(i, 18'($urandom), ($urandom_range(0, 9) != 0) ? 1 : 0,
                            len, $urandom_range(0, len), $urandom_range(0, 1));
                end
            end
            wait_idle(2000);
        end

        // Reset in the middle of RUN.
        request(1, 18'($urandom), 1, 100, 50, 0);
        len = 0;
        while (eng_busy !== 1'b1 && len < 50) begin
            @(negedge clk);
            len++;
        end
        check("rst_run_reached", eng_busy, 1);
        repeat (10) @(posedge clk);
        #1;
        eng_kill = 1'b1;
        reset    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_zero("reset_run");
        sb_q.delete();
        @(posedge clk);
        #1;
        reset    = 1'b0;
        eng_kill = 1'b0;
        grant_log.delete();
        for (int i = 0; i < NUM_REQ; i++)
            request(i, 18'($urandom), 1, 2, 1, 0);
        wait_idle(500);
        check("post_reset_first", grant_log.size() > 0 ? grant_log[0] : -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : guard
        #(600000);
        $display("FAIL global_timeout: simulation did not finish in time");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "global timeout");
    end

endmodule
